mdu_unit: RTL and testbench
===========================

Name: mdu_unit

Overview:
- Multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Consumes the MDUOp/MDUStart control and the forwarded rs/rt operands delivered by the D→E pipeline register.
- Owns the HI/LO registers and drives Busy, which the hazard unit uses to stall mult/div/mfhi/mflo/mthi/mtlo in D.

Parameters:
- MULT_CYCLES, 5, Busy cycles for mult/multu (and madd/msub when enabled); legal range ≥ 1.
- DIV_CYCLES, 10, Busy cycles for div/divu; legal range ≥ 1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous active-low reset: reset==0 at posedge clears state.
- MDUStart  in  1  one-cycle start strobe for mult/multu/div/divu (and madd family).
- MDUOp  in  4  operation code; encodings are defined in mdu_pkg.
- A  in  32  operand rs (forwarded).
- B  in  32  operand rt (forwarded).
- Busy  out  1  high while an operation is in flight.
- HI  out  32  HI register.
- LO  out  32  LO register.
- MDUOut  out  32  combinational read value: HI for mfhi, LO for mflo, 0 otherwise.

Behaviour:
- Opcodes: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO. Codes 9–15 are NOP unless the optional feature enables them.
- Reset (reset==0 at posedge): Busy=0, HI=0, LO=0, counter=0, state=IDLE, pending result registers = 0. Reset wins over every other event, including mid-operation; an in-flight result is discarded.
- FSM states:
  - IDLE: if MDUStart=1 and MDUOp ∈ {MULT, MULTU, DIV, DIVU}, latch the result into pending_hi/pending_lo, load counter with MULT_CYCLES or DIV_CYCLES, go to BUSY. Any other op with MDUStart=1 stays in IDLE.
  - BUSY: Busy=1; counter decrements each cycle. When counter==1, the posedge commits HI<=pending_hi and LO<=pending_lo and returns to IDLE.
- Timing: Busy rises the cycle after the MDUStart cycle and stays high exactly N cycles. New HI/LO are visible in the cycle Busy falls.
- Busy is registered. Hazard stalling uses MDUStart|Busy externally.
- Arithmetic:
  - MULT: {HI,LO} = signed 64-bit product.
  - MULTU: {HI,LO} = unsigned 64-bit product.
  - DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - DIVU: unsigned quotient and remainder.
  - Divide by zero: Busy runs the full DIV_CYCLES; HI/LO are left unchanged.
- MTHI/MTLO: write A into HI/LO at the posedge, only in IDLE. Ignored while BUSY.
- MFHI/MFLO: MDUOut reflects the current HI/LO combinationally. No wait on Busy; the hazard unit stalls them instead.
- MDUStart while BUSY is ignored: no restart, no latch.
- MDUStart with MDUOp NONE or a move op is treated as no start.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: adds opcodes 9 MADD, 10 MADDU, 11 MSUB, 12 MSUBU.
  - On start, pending = {HI,LO} ± 64-bit product (signed/unsigned).
  - Uses MULT_CYCLES; HI/LO are sampled at the start cycle.
- Undefined: codes 9–12 are NOP and never start the FSM.

Decomposition:
- mdu_pkg holds:
  - the MDUOp encoding constants;
  - the FSM state enum {IDLE, BUSY};
  - the counter width constant (clog2 of max(MULT_CYCLES, DIV_CYCLES) + 1).
- One sub-module, mdu_arith: purely combinational. Takes op, A, B, HI, LO; returns the 64-bit {hi,lo} result and a div0 flag. mdu_unit holds the FSM, counter and registers.

Test Plan:
- Reset held low 2 cycles mid-DIV, then released → Busy=0, HI=LO=0. A following MTLO A=5 gives LO=5 next cycle.
- MULT A=0xFFFFFFFE(-2), B=3, start at cycle t → Busy high t+1..t+5. At t+6, HI=0xFFFFFFFF, LO=0xFFFFFFFA; MFLO MDUOut=0xFFFFFFFA.
- DIV A=-7 (0xFFFFFFF9), B=2 → after 10 Busy cycles LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU with same operands gives LO=0x7FFFFFFC, HI=1.
- DIVU A=9, B=0 with HI=0x11, LO=0x22 preloaded → Busy for 10 cycles; HI=0x11, LO=0x22 unchanged.
- During BUSY from MULTU 0xFFFFFFFF×0xFFFFFFFF, issue MTHI A=0xAB and a second MDUStart DIV → both ignored. Final HI=0xFFFFFFFE, LO=0x00000001.
- With MDU_MADD_EN: HI=0, LO=10, MADD A=3, B=4 → after 5 cycles LO=22, HI=0. Without the macro, op 9 leaves Busy=0 and HI/LO unchanged.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: opcodes, FSM states,
// counter sizing. Optional MADD/MSUB family enabled by MDU_MADD_EN.
package mdu_pkg;

   localparam logic [3:0] OP_NONE  = 4'd0;
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;
   localparam logic [3:0] OP_MADD  = 4'd9;
   localparam logic [3:0] OP_MADDU = 4'd10;
   localparam logic [3:0] OP_MSUB  = 4'd11;
   localparam logic [3:0] OP_MSUBU = 4'd12;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   function automatic int cnt_width(int m, int d);
      int mx;
      mx = (m > d) ? m : d;
      return $clog2(mx) + 1;
   endfunction

   localparam int CNT_W = cnt_width(5, 10);

   // Ops that launch a multi-cycle operation.
   function automatic logic is_start(logic [3:0] op);
      logic r;
      r = 1'b0;
      if (op == OP_MULT || op == OP_MULTU ||
          op == OP_DIV  || op == OP_DIVU)
         r = 1'b1;
`ifdef MDU_MADD_EN
      if (op == OP_MADD || op == OP_MADDU ||
          op == OP_MSUB || op == OP_MSUBU)
         r = 1'b1;
`endif
      return r;
   endfunction

   function automatic logic is_div(logic [3:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational datapath: product/quotient/remainder into a 64-bit {hi,lo}.
// Ports: op_i, a_i, b_i, hi_i, lo_i in; res_o {hi,lo}, div0_o out.
// Accumulate ops exist only when MDU_MADD_EN is defined.
module mdu_arith
   import mdu_pkg::*;
(
   input  logic [3:0]  op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic [31:0] hi_i,
   input  logic [31:0] lo_i,
   output logic [63:0] res_o,
   output logic        div0_o
);

   logic [63:0] sprod;
   logic [63:0] uprod;
   logic        sdiv;
   logic [31:0] ma, mb, dvs;
   logic [31:0] q, r, sq, sr;

   always_comb begin
      sprod = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
      uprod = {32'd0, a_i} * {32'd0, b_i};
      // One unsigned divider on magnitudes; signs fixed up afterwards,
      // which also makes 0x80000000 / -1 wrap cleanly.
      sdiv  = (op_i == OP_DIV);
      ma    = (sdiv && a_i[31]) ? -a_i : a_i;
      mb    = (sdiv && b_i[31]) ? -b_i : b_i;
      dvs   = (mb == 32'd0) ? 32'd1 : mb;
      q     = ma / dvs;
      r     = ma % dvs;
      sq    = (sdiv && (a_i[31] ^ b_i[31])) ? -q : q;
      sr    = (sdiv && a_i[31]) ? -r : r;

      res_o  = {hi_i, lo_i};
      div0_o = 1'b0;
      unique case (1'b1)
         op_i == OP_MULT:  res_o = sprod;
         op_i == OP_MULTU: res_o = uprod;
         op_i == OP_DIV,
         op_i == OP_DIVU: begin
            if (b_i == 32'd0) div0_o = 1'b1;
            else              res_o  = {sr, sq};
         end
`ifdef MDU_MADD_EN
         op_i == OP_MADD:  res_o = {hi_i, lo_i} + sprod;
         op_i == OP_MADDU: res_o = {hi_i, lo_i} + uprod;
         op_i == OP_MSUB:  res_o = {hi_i, lo_i} - sprod;
         op_i == OP_MSUBU: res_o = {hi_i, lo_i} - uprod;
`endif
         default: ;
      endcase
   end

endmodule

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit owning HI/LO; Busy feeds the hazard unit.
// Ports: clk, reset (sync, active-low), MDUStart, MDUOp, A, B in;
// Busy, HI, LO, MDUOut out. MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU.
module mdu_unit
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MDUStart,
   input  logic [3:0]  MDUOp,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] MDUOut
);

   localparam int CW = cnt_width(MULT_CYCLES, DIV_CYCLES);

   state_e      state_q, state_d;
   logic [CW-1:0] cnt_q;
   logic [31:0] hi_q, lo_q;
   logic [31:0] pend_hi_q, pend_lo_q;
   logic        div0_q;

   logic [63:0] res;
   logic        div0;
   logic        go;
   logic        busy_s, load_s, commit_s, idle_s;

   mdu_arith u_arith (
      .op_i   (MDUOp),
      .a_i    (A),
      .b_i    (B),
      .hi_i   (hi_q),
      .lo_i   (lo_q),
      .res_o  (res),
      .div0_o (div0)
   );

   assign go = MDUStart && is_start(MDUOp);

   always_ff @(posedge clk) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (go) state_d = BUSY;
         BUSY: if (cnt_q == CW'(1)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      idle_s   = (state_q == IDLE);
      busy_s   = (state_q == BUSY);
      load_s   = idle_s && go;
      commit_s = busy_s && (cnt_q == CW'(1));
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
         div0_q    <= 1'b0;
      end else begin
         if (load_s) begin
            pend_hi_q <= res[63:32];
            pend_lo_q <= res[31:0];
            div0_q    <= div0;
            cnt_q     <= is_div(MDUOp) ? CW'(DIV_CYCLES)
                                       : CW'(MULT_CYCLES);
         end else if (busy_s) begin
            cnt_q <= cnt_q - CW'(1);
         end
         // A divide by zero still runs its cycles but never commits.
         if (commit_s && !div0_q) begin
            hi_q <= pend_hi_q;
            lo_q <= pend_lo_q;
         end else if (idle_s && MDUOp == OP_MTHI) begin
            hi_q <= A;
         end else if (idle_s && MDUOp == OP_MTLO) begin
            lo_q <= A;
         end
      end
   end

   assign Busy   = busy_s;
   assign HI     = hi_q;
   assign LO     = lo_q;
   assign MDUOut = (MDUOp == OP_MFHI) ? hi_q :
                   (MDUOp == OP_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit with an arithmetic reference model
// compared every cycle plus literal expectations per scenario.
module tb_mdu_unit;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        MDUStart;
   logic [3:0]  MDUOp;
   logic [31:0] A, B;
   logic        Busy;
   logic [31:0] HI, LO, MDUOut;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk      (clk),
      .reset    (reset),
      .MDUStart (MDUStart),
      .MDUOp    (MDUOp),
      .A        (A),
      .B        (B),
      .Busy     (Busy),
      .HI       (HI),
      .LO       (LO),
      .MDUOut   (MDUOut)
   );

   always #5 clk = ~clk;

   // Reference model: remaining busy cycles and a pending 64-bit result.
   logic [31:0] m_hi = 0, m_lo = 0;
   logic [63:0] m_pend;
   bit          m_div0;
   int          m_left = 0;

   function automatic bit starts(logic [3:0] op);
      if (op >= 4'd1 && op <= 4'd4) return 1'b1;
`ifdef MDU_MADD_EN
      if (op >= 4'd9 && op <= 4'd12) return 1'b1;
`endif
      return 1'b0;
   endfunction

   always @(posedge clk) begin
      longint sa, sb, sq, sr;
      logic [63:0] up, sp, acc;
      if (!reset) begin
         m_hi = 0; m_lo = 0; m_left = 0;
      end else if (m_left > 0) begin
         m_left = m_left - 1;
         if (m_left == 0 && !m_div0) begin
            m_hi = m_pend[63:32];
            m_lo = m_pend[31:0];
         end
      end else if (MDUStart && starts(MDUOp)) begin
         sa = longint'($signed(A));
         sb = longint'($signed(B));
         up = {32'd0, A} * {32'd0, B};
         sp = 64'(sa * sb);
         acc = {m_hi, m_lo};
         m_div0 = 1'b0;
         m_pend = acc;
         m_left = (MDUOp == 4'd3 || MDUOp == 4'd4) ? DC : MC;
         case (MDUOp)
            4'd1: m_pend = sp;
            4'd2: m_pend = up;
            4'd3: if (B == 0) m_div0 = 1'b1;
                  else begin
                     sq = sa / sb;
                     sr = sa % sb;
                     m_pend = {sr[31:0], sq[31:0]};
                  end
            4'd4: if (B == 0) m_div0 = 1'b1;
                  else m_pend = {A % B, A / B};
            4'd9:  m_pend = acc + sp;
            4'd10: m_pend = acc + up;
            4'd11: m_pend = acc - sp;
            4'd12: m_pend = acc - up;
            default: ;
         endcase
      end else if (MDUOp == 4'd7) begin
         m_hi = A;
      end else if (MDUOp == 4'd8) begin
         m_lo = A;
      end
   end

   always @(negedge clk) begin
      logic [31:0] eo;
      if (chk_en) begin
         eo = (MDUOp == 4'd5) ? m_hi : (MDUOp == 4'd6) ? m_lo : 32'd0;
         checks += 4;
         if (Busy !== (m_left > 0)) begin
            errors++;
            $display("FAIL model_busy t=%0t got %b want %b",
                     $time, Busy, (m_left > 0));
         end
         if (HI !== m_hi) begin
            errors++;
            $display("FAIL model_hi t=%0t got %h want %h", $time, HI, m_hi);
         end
         if (LO !== m_lo) begin
            errors++;
            $display("FAIL model_lo t=%0t got %h want %h", $time, LO, m_lo);
         end
         if (MDUOut !== eo) begin
            errors++;
            $display("FAIL model_out t=%0t got %h want %h", $time, MDUOut, eo);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic s, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b);
      MDUStart = s; MDUOp = op; A = a; B = b;
      cyc(1);
      MDUStart = 1'b0; MDUOp = 4'd0; A = 0; B = 0;
   endtask

   initial begin
      reset = 1'b0; MDUStart = 1'b0; MDUOp = 4'd0; A = 0; B = 0;
      cyc(1);
      chk_en = 1'b1;
      cyc(1);
      reset = 1'b1;
      cyc(1);
      chk("reset_busy", {31'd0, Busy}, 32'd0);
      chk("reset_hi", HI, 32'd0);

      // Reset in the middle of a divide discards everything.
      drive(0, 4'd7, 32'h77, 0);
      drive(1, 4'd3, 32'd100, 32'd7);
      cyc(3);
      reset = 1'b0;
      cyc(2);
      reset = 1'b1;
      chk("rst_mid_busy", {31'd0, Busy}, 32'd0);
      chk("rst_mid_hi", HI, 32'd0);
      chk("rst_mid_lo", LO, 32'd0);
      drive(0, 4'd8, 32'd5, 0);
      chk("mtlo", LO, 32'd5);

      // MULT -2 * 3: Busy for exactly 5 cycles.
      drive(1, 4'd1, 32'hFFFFFFFE, 32'd3);
      chk("mult_busy_first", {31'd0, Busy}, 32'd1);
      cyc(4);
      chk("mult_busy_last", {31'd0, Busy}, 32'd1);
      cyc(1);
      chk("mult_busy_fall", {31'd0, Busy}, 32'd0);
      chk("mult_hi", HI, 32'hFFFFFFFF);
      chk("mult_lo", LO, 32'hFFFFFFFA);
      MDUOp = 4'd6;
      #1;
      chk("mflo", MDUOut, 32'hFFFFFFFA);
      MDUOp = 4'd5;
      #1;
      chk("mfhi", MDUOut, 32'hFFFFFFFF);
      MDUOp = 4'd0;

      // Signed and unsigned divide of -7 by 2.
      drive(1, 4'd3, 32'hFFFFFFF9, 32'd2);
      cyc(9);
      chk("div_busy_last", {31'd0, Busy}, 32'd1);
      cyc(1);
      chk("div_lo", LO, 32'hFFFFFFFD);
      chk("div_hi", HI, 32'hFFFFFFFF);
      drive(1, 4'd4, 32'hFFFFFFF9, 32'd2);
      cyc(10);
      chk("divu_lo", LO, 32'h7FFFFFFC);
      chk("divu_hi", HI, 32'h1);

      // Divide by zero keeps HI/LO.
      drive(0, 4'd7, 32'h11, 0);
      drive(0, 4'd8, 32'h22, 0);
      drive(1, 4'd4, 32'd9, 32'd0);
      cyc(9);
      chk("div0_busy_last", {31'd0, Busy}, 32'd1);
      cyc(1);
      chk("div0_busy_fall", {31'd0, Busy}, 32'd0);
      chk("div0_hi", HI, 32'h11);
      chk("div0_lo", LO, 32'h22);

      // MTHI and restart ignored while busy.
      drive(1, 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
      drive(0, 4'd7, 32'hAB, 0);
      drive(1, 4'd3, 32'd50, 32'd3);
      cyc(3);
      chk("multu_busy_fall", {31'd0, Busy}, 32'd0);
      chk("multu_hi", HI, 32'hFFFFFFFE);
      chk("multu_lo", LO, 32'h00000001);

      // Start with a move op does not launch.
      drive(1, 4'd5, 32'h1, 32'h1);
      chk("mf_nostart", {31'd0, Busy}, 32'd0);

      // Signed overflow divide.
      drive(1, 4'd3, 32'h80000000, 32'hFFFFFFFF);
      cyc(10);
      chk("divov_lo", LO, 32'h80000000);
      chk("divov_hi", HI, 32'h0);

`ifdef MDU_MADD_EN
      drive(0, 4'd7, 32'd0, 0);
      drive(0, 4'd8, 32'd10, 0);
      drive(1, 4'd9, 32'd3, 32'd4);
      cyc(5);
      chk("madd_lo", LO, 32'd22);
      chk("madd_hi", HI, 32'd0);
`else
      drive(1, 4'd9, 32'd3, 32'd4);
      chk("op9_busy", {31'd0, Busy}, 32'd0);
      cyc(5);
      chk("op9_lo", LO, 32'h80000000);
      chk("op9_hi", HI, 32'h0);
`endif

      cyc(2);
      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
